// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader that fills instruction memory and releases the CPU
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte, CHECK/ERROR states)
// Ports: clk, rst (async, active high) | rx_data, rx_valid, rx_ready: byte input handshake
//        im_we, im_addr, im_wdata: instruction-memory write | cpu_rstd: CPU reset, low holds it
//        busy, done, err: load status
module prog_loader #(
   parameter int ADDR_W     = 8,
   parameter bit BIG_ENDIAN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rstd,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [2:0] {
      IDLE, DATA, WRITE, DONE
`ifdef LOADER_CHECKSUM_EN
      , CHECK, ERROR
`endif
   } state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic              acc, start, last;
   assign acc  = rx_valid & rx_ready;
   // count byte doubles as the COUNT state: captured in IDLE/DONE/ERROR straight into DATA
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   assign start = acc & (state_q == IDLE | state_q == DONE | state_q == ERROR);
`else
   assign start = acc & (state_q == IDLE | state_q == DONE);
`endif
   // count 0 wraps to all-ones, so N=0 ends at the last address
   assign last = addr_q == cnt_q - ADDR_W'(1);
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      if (start) begin
         state_d = DATA;
         cnt_d   = ADDR_W'(rx_data);
         addr_d  = '0;
         idx_d   = 2'd0;
      end else if (acc && state_q == DATA) begin
         word_d  = BIG_ENDIAN ? {word_q[23:0], rx_data} : {rx_data, word_q[31:8]};
         idx_d   = idx_q + 2'd1;
         state_d = idx_q == 2'd3 ? WRITE : DATA;
      end else if (state_q == WRITE) begin
         addr_d  = addr_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
         state_d = last ? CHECK : DATA;
      end else if (acc && state_q == CHECK) begin
         state_d = rx_data == csum_q ? DONE : ERROR;
`else
         state_d = last ? DONE : DATA;
`endif
      end
   end
`ifdef LOADER_CHECKSUM_EN
   assign csum_d = start ? 8'h00 : (acc && state_q == DATA) ? csum_q ^ rx_data : csum_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) csum_q <= 8'h00;
      else     csum_q <= csum_d;
   assign err  = state_q == ERROR;
   assign busy = state_q == DATA | state_q == WRITE | state_q == CHECK;
`else
   assign err  = 1'b0;
   assign busy = state_q == DATA | state_q == WRITE;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   // rst gates ready so it is low during reset yet high on the first cycle after release
   assign rx_ready = !rst && state_q != WRITE;
   assign im_we    = state_q == WRITE;
   assign im_addr  = addr_q;
   assign im_wdata = word_q;
   assign cpu_rstd = state_q == DONE;
   assign done     = state_q == DONE;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (big- and little-endian instances)
module tb_prog_loader;
   logic        clk, rst, rx_valid;
   logic [7:0]  rx_data;
   logic        be_ready, be_we, be_rstd, be_busy, be_done, be_err;
   logic [7:0]  be_addr;
   logic [31:0] be_wdata;
   logic        le_ready, le_we, le_rstd, le_busy, le_done, le_err;
   logic [7:0]  le_addr;
   logic [31:0] le_wdata;
   int          errors = 0, checks = 0;
   logic [7:0]  be_wa [512];
   logic [31:0] be_wd [512];
   logic [31:0] le_wd [512];
   int          be_n = 0, le_n = 0;

   prog_loader #(.ADDR_W(8), .BIG_ENDIAN(1)) u_be (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(be_ready),
      .im_we(be_we), .im_addr(be_addr), .im_wdata(be_wdata), .cpu_rstd(be_rstd),
      .busy(be_busy), .done(be_done), .err(be_err));
   prog_loader #(.ADDR_W(8), .BIG_ENDIAN(0)) u_le (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(le_ready),
      .im_we(le_we), .im_addr(le_addr), .im_wdata(le_wdata), .cpu_rstd(le_rstd),
      .busy(le_busy), .done(le_done), .err(le_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (be_we) begin
         be_wa[be_n] <= be_addr;
         be_wd[be_n] <= be_wdata;
         be_n        <= be_n + 1;
      end
      if (le_we) begin
         le_wd[le_n] <= le_wdata;
         le_n        <= le_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!be_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'b0, be_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_we"},    {31'b0, be_we},    0);
      chk({tag, "_addr"},  {24'b0, be_addr},  0);
      chk({tag, "_wdata"}, be_wdata,          0);
      chk({tag, "_rstd"},  {31'b0, be_rstd},  0);
      chk({tag, "_ready"}, {31'b0, be_ready}, 0);
      chk({tag, "_busy"},  {31'b0, be_busy},  0);
      chk({tag, "_done"},  {31'b0, be_done},  0);
      chk({tag, "_err"},   {31'b0, be_err},   0);
   endtask

   function automatic logic [31:0] wv(input int k);
      logic [7:0] b = k[7:0];
      return {b, b * 8'd3, ~b, b + 8'h77};
   endfunction

   initial begin
      int base, lbase, g;
      logic [7:0] cs, bt;
      logic [31:0] w;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      reset_checks("rst0");
      rst = 1'b0;
      #1 chk("ready_after_rst", {31'b0, be_ready}, 1);

      base = be_n; lbase = le_n;
      send(8'h02);
      send(8'h20); send(8'h01); send(8'h00); send(8'h05);
      send(8'h8C); send(8'h22); send(8'h00); send(8'h04);
      chk("t1_write_we",    {31'b0, be_we},    1);
      chk("t1_write_addr",  {24'b0, be_addr},  1);
      chk("t1_write_data",  be_wdata,          32'h8C220004);
      chk("t1_le_data",     le_wdata,          32'h0400228C);
      chk("t1_write_ready", {31'b0, be_ready}, 0);
      chk("t1_write_busy",  {31'b0, be_busy},  1);
      chk("t1_write_rstd",  {31'b0, be_rstd},  0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h8E);
`else
      @(negedge clk);
`endif
      chk("t1_done",     {31'b0, be_done}, 1);
      chk("t1_rstd",     {31'b0, be_rstd}, 1);
      chk("t1_busy",     {31'b0, be_busy}, 0);
      chk("t1_le_done",  {31'b0, le_done}, 1);
      chk("t1_nwrites",  be_n - base, 2);
      chk("t1_addr0",    {24'b0, be_wa[base]},   0);
      chk("t1_data0",    be_wd[base],            32'h20010005);
      chk("t1_addr1",    {24'b0, be_wa[base+1]}, 1);
      chk("t1_data1",    be_wd[base+1],          32'h8C220004);
      chk("t1_le_n",     le_n - lbase, 2);
      chk("t1_le_data0", le_wd[lbase],   32'h05000120);
      chk("t1_le_data1", le_wd[lbase+1], 32'h0400228C);

      base = be_n; cs = 8'h00;
      send(8'h00);
      chk("t2_restart_done", {31'b0, be_done}, 0);
      chk("t2_restart_rstd", {31'b0, be_rstd}, 0);
      chk("t2_restart_busy", {31'b0, be_busy}, 1);
      for (int k = 0; k < 256; k++) begin
         w = wv(k);
         for (int j = 0; j < 4; j++) begin
            if (j != 0) begin
               g = $urandom_range(0, 3);
               repeat (g) begin
                  chk("t2_gap_no_we", {31'b0, be_we}, 0);
                  @(negedge clk);
               end
            end
            bt = w[31-8*j -: 8];
            cs ^= bt;
            send(bt);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send(cs);
`else
      @(negedge clk);
`endif
      chk("t2_nwrites", be_n - base, 256);
      chk("t2_addr_wrap", {24'b0, be_addr}, 0);
      chk("t2_done", {31'b0, be_done}, 1);
      for (int k = 0; k < 256; k++) begin
         chk("t2_entry_addr", {24'b0, be_wa[base+k]}, k);
         chk("t2_entry_data", be_wd[base+k], wv(k));
      end

      base = be_n;
      send(8'h01); send(8'hAA); send(8'hBB);
      rst = 1'b1;
      #1 reset_checks("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      #1;
      send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef LOADER_CHECKSUM_EN
      send(8'h44);
`else
      @(negedge clk);
`endif
      chk("t3_nwrites", be_n - base, 1);
      chk("t3_addr",    {24'b0, be_wa[base]}, 0);
      chk("t3_data",    be_wd[base], 32'h11223344);
      chk("t3_done",    {31'b0, be_done}, 1);
      chk("t3_rstd",    {31'b0, be_rstd}, 1);

`ifdef LOADER_CHECKSUM_EN
      send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h45);
      chk("t4_err",  {31'b0, be_err},  1);
      chk("t4_rstd", {31'b0, be_rstd}, 0);
      chk("t4_done", {31'b0, be_done}, 0);
      send(8'h01);
      chk("t4_err_clr", {31'b0, be_err}, 0);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h44);
      chk("t4_retry_done", {31'b0, be_done}, 1);
      chk("t4_retry_err",  {31'b0, be_err},  0);
      chk("t4_retry_rstd", {31'b0, be_rstd}, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: instruction-memory address width (256 words).
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1: 1 means the first received byte is bits [31:24]; 0 means the first byte is bits [7:0].
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data is valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-008 im_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 im_addr  output  ADDR_W  instruction-memory write address.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_rstd  output  1  active-low reset for the processor; 0 holds the CPU in reset.
REQ-012 busy  output  1  a load is in progress.
REQ-013 done  output  1  the last load completed successfully.
REQ-014 err  output  1  the last load failed its checksum (only with LOADER_CHECKSUM_EN).

Function
REQ-015 The block SHALL implement the states IDLE, COUNT, DATA, WRITE, CHECK, DONE and ERROR.
REQ-016 IDLE: rx_ready=1, cpu_rstd=0; the first accepted byte is the word count N (0 means 2^ADDR_W words); the block then enters DATA with im_addr=0 and byte index 0; COUNT is the one-cycle alias of this capture and SHALL NOT take an extra cycle.
REQ-017 DATA: rx_ready=1; each accepted byte shifts into the word per BIG_ENDIAN; the 4th accepted byte moves the block to WRITE on the next edge.
REQ-018 WRITE: exactly one cycle with im_we=1, rx_ready=0 and im_wdata equal to the assembled word at the current im_addr.
REQ-019 After WRITE, im_addr SHALL increment by 1 modulo 2^ADDR_W; the block returns to DATA if words remain, otherwise it goes to CHECK (macro defined) or DONE (macro undefined).
REQ-020 Gaps in rx_valid SHALL NOT change state, the byte index or the partial word.
REQ-021 busy SHALL be 1 in DATA, WRITE and CHECK, and 0 otherwise.
REQ-022 DONE: cpu_rstd=1, done=1, rx_ready=1; an accepted byte is a new word count and restarts a load with cpu_rstd=0 and done=0 on the next cycle.
REQ-023 ERROR: cpu_rstd=0, err=1, rx_ready=1; an accepted byte is a new word count, clears err and restarts the load.
REQ-024 Latency: cpu_rstd SHALL rise on the first clock edge after the final WRITE cycle (macro undefined) or after the checksum byte is accepted (macro defined).
REQ-025 N=2^ADDR_W SHALL fill every address, with im_addr wrapping to 0 after the final write.

Reset
REQ-026 While rst=1, outputs SHALL be: im_we=0, im_addr=0, im_wdata=0, cpu_rstd=0, rx_ready=0, busy=0, done=0, err=0; state SHALL be IDLE.
REQ-027 A reset asserted mid-load SHALL abandon the partial word; words already written are not rolled back.
REQ-028 After reset is released, the block SHALL accept a new count byte starting on the first cycle.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, the block SHALL keep a running 8-bit XOR of all data bytes (the count byte is excluded).
REQ-030 With LOADER_CHECKSUM_EN defined, the block SHALL accept one more byte in CHECK and go to DONE if that byte equals the XOR, or to ERROR if it does not.
REQ-031 With LOADER_CHECKSUM_EN undefined, CHECK and ERROR SHALL NOT exist, err SHALL be tied to 0, and no trailing byte SHALL be consumed.

Verification
REQ-032 The bench SHALL send 02, 20 01 00 05, 8C 22 00 04 with BIG_ENDIAN=1 and the macro undefined -> writes 0x20010005@0 and 0x8C220004@1, then cpu_rstd=1 and done=1 one cycle after the second WRITE.
REQ-033 The bench SHALL send the same stream with BIG_ENDIAN=0 -> writes 0x05000120@0 and 0x0400228C@1.
REQ-034 The bench SHALL run with the macro defined and send 01, 11 22 33 44, 44 -> write 0x11223344@0, then done=1, err=0 and cpu_rstd=1.
REQ-035 The bench SHALL send the same stream with checksum byte 45 -> err=1, cpu_rstd=0; a following retry with checksum 44 -> done=1 and err=0.
REQ-036 The bench SHALL send count 00 with 1024 data bytes and random rx_valid gaps -> 256 writes at addresses 0..255, im_addr wraps to 0, and no write occurs while rx_valid is low.
REQ-037 The bench SHALL assert rst after 2 bytes of word 1 -> all outputs take their reset values immediately, and a subsequent count 01 plus 4 bytes writes address 0.
